bin_bcd_seq_ctrl: RTL and testbench
===================================

BIN_BCD_SEQ_CTRL -- requirements
Module: bin_bcd_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: binary operand width in bits.
REQ-002 Parameter DIGITS, default 3: number of BCD digits. The chosen value SHALL satisfy 10**DIGITS > 2**WIDTH - 1.
REQ-003 clk  input  1: single clock; all state changes on its rising edge.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 start  input  1: conversion request; sampled only in IDLE.
REQ-006 bin_in  input  WIDTH: operand; captured on the edge that accepts start.
REQ-007 busy  output  1: high while state is not IDLE.
REQ-008 done  output  1: one-cycle pulse when a result is published.
REQ-009 bcd_out  output  DIGITS*4: last completed result; digit 0 (units) in [3:0].
REQ-010 seg_out  output  DIGITS*7: active-low 7-segment patterns; digit 0 in [6:0], bit order g..a.

Function
REQ-011 Conversion SHALL use sequential shift-add-3 (double dabble), one operand bit per cycle, MSB first.
REQ-012 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-013 IDLE -> SHIFT when start=1; on that edge: bin_in is latched, the BCD scratch register is cleared, and the bit counter is loaded with WIDTH.
REQ-014 Each SHIFT cycle SHALL do the following:
- Add 3 to every scratch digit that is >= 5.
- Shift the scratch register left by one, taking the next operand MSB into bit 0.
- Decrement the counter.
REQ-015 SHIFT -> DONE on the edge performing the final (WIDTH-th) shift; DONE -> IDLE unconditionally on the next edge.
REQ-016 Latency: with start accepted at edge E, done SHALL be high in exactly the cycle following edge E+WIDTH, and low otherwise.
REQ-017 bcd_out and seg_out SHALL update only on the edge entering DONE, and hold their value between conversions.
REQ-018 start while busy=1, including the DONE cycle, SHALL be ignored and not queued. Back-to-back throughput is one conversion per WIDTH+2 cycles.
REQ-019 bin_in changes after acceptance SHALL NOT affect the running conversion.
REQ-020 Segment decode patterns (gfedcba, active-low):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Any value above 9 SHALL give blank (1111111).
REQ-021 Scratch digit arithmetic is 4-bit. The add-3 result is always <= 12 before the shift, so no carry between digits is permitted or needed.

Reset
REQ-022 On rst=1 the block SHALL set:
- state=IDLE, busy=0, done=0
- bcd_out=0, counter=0, scratch=0
- seg_out all blank (1111111)
REQ-023 rst during SHIFT or DONE SHALL abort: no done pulse, and outputs take their reset values.
REQ-024 rst has priority over start on the same edge.

Structure
REQ-025 A shared package SHALL hold:
- the FSM state enum
- the segment-pattern constants for 0-9 and blank
- SEG_W=7 and BCD_DIGIT_W=4
REQ-026 One sub-module, bcd_to_seg (4-bit digit in, 7-bit active-low pattern out, combinational), SHALL be instantiated DIGITS times on bcd_out.

Verification
REQ-027 Reset, then bin_in=255 with start for 1 cycle -> done 9 cycles later; bcd_out=0x255; seg_out = {0100100, 0010010, 0010010}.
REQ-028 bin_in=0 -> bcd_out=0x000; all three segs 1000000. bin_in=9 -> bcd_out=0x009; seg digit0=0010000.
REQ-029 start held high continuously with bin_in=100 then 37 -> conversions complete at 10-cycle spacing; results 0x100 then 0x037. No start is accepted during busy, or in the DONE cycle.
REQ-030 bin_in changed to 0 three cycles after start of 128 -> result 0x128.
REQ-031 rst asserted 4 cycles into a conversion -> no done pulse; bcd_out=0; seg_out blank; a new start converts correctly.
REQ-032 Exhaustive sweep 0..255 -> each bcd_out matches a decimal reference model, with exactly one done per start.

Source files
------------

// File: rtl/bin_bcd_seq_ctrl_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter
// and its 7-segment decode.
package bin_bcd_seq_ctrl_pkg;

   localparam int unsigned SEG_W       = 7;
   localparam int unsigned BCD_DIGIT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Active-low patterns, bit order g..a
   localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
   localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
   localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
   localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
   localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
   localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
   localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
   localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bin_bcd_seq_ctrl_if.sv
// Request/result bundle between a requester and the BCD converter.
interface bin_bcd_seq_ctrl_if
   import bin_bcd_seq_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DIGITS = 3
);

   logic                          start;
   logic [WIDTH-1:0]              bin_in;
   logic                          busy;
   logic                          done;
   logic [DIGITS*BCD_DIGIT_W-1:0] bcd_out;
   logic [DIGITS*SEG_W-1:0]       seg_out;

   modport master (
      output start, bin_in,
      input  busy, done, bcd_out, seg_out
   );

   modport slave (
      input  start, bin_in,
      output busy, done, bcd_out, seg_out
   );

endinterface

// File: rtl/bin_bcd_seq_ctrl_seg.sv
// Combinational BCD digit to active-low 7-segment decode; non-decimal
// codes blank the display.
module bcd_to_seg
   import bin_bcd_seq_ctrl_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] i_digit,
   output logic [SEG_W-1:0]       o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      case (i_digit)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/bin_bcd_seq_ctrl.sv
// Sequential double-dabble binary-to-BCD converter, one operand bit per
// cycle MSB first, with registered BCD result and 7-segment decode.
module bin_bcd_seq_ctrl
   import bin_bcd_seq_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DIGITS = 3
)
(
   input  logic                clk,
   input  logic                rst,
   bin_bcd_seq_ctrl_if.slave   bus
);

   localparam int unsigned BCD_W = DIGITS * BCD_DIGIT_W;
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   state_t                  r_state;
   state_t                  w_state_next;
   logic [WIDTH-1:0]        r_bin;
   logic [BCD_W-1:0]        r_scratch;
   logic [BCD_W-1:0]        r_bcd;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_valid;
   logic [BCD_W-1:0]        w_adj;
   logic [BCD_W-1:0]        w_scratch_next;
   logic [DIGITS*SEG_W-1:0] w_seg;
   logic                    w_last;

   assign w_last = (r_cnt == CNT_W'(1));

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (bus.start) w_state_next = ST_SHIFT;
         ST_SHIFT: if (w_last)    w_state_next = ST_DONE;
         ST_DONE:                 w_state_next = ST_IDLE;
         default:                 w_state_next = ST_IDLE;
      endcase
   end

   // Digits cap at 12 after add-3, so each nibble is adjusted independently
   always_comb begin
      w_adj = r_scratch;
      for (int unsigned d = 0; d < DIGITS; d++) begin
         if (r_scratch[d*BCD_DIGIT_W +: BCD_DIGIT_W] >= 4'd5)
            w_adj[d*BCD_DIGIT_W +: BCD_DIGIT_W] = r_scratch[d*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd3;
      end
      w_scratch_next = {w_adj[BCD_W-2:0], r_bin[WIDTH-1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bin     <= '0;
         r_scratch <= '0;
         r_bcd     <= '0;
         r_cnt     <= '0;
         r_valid   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_bin     <= bus.bin_in;
                  r_scratch <= '0;
                  r_cnt     <= CNT_W'(WIDTH);
               end
            end
            ST_SHIFT: begin
               r_scratch <= w_scratch_next;
               r_bin     <= {r_bin[WIDTH-2:0], 1'b0};
               r_cnt     <= r_cnt - CNT_W'(1);
               if (w_last) begin
                  r_bcd   <= w_scratch_next;
                  r_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_seg
      bcd_to_seg u_seg (
         .i_digit (r_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .o_seg   (w_seg[g*SEG_W +: SEG_W])
      );
   end

   // Display stays blank until the first conversion after reset completes
   assign bus.busy    = (r_state != ST_IDLE);
   assign bus.done    = (r_state == ST_DONE);
   assign bus.bcd_out = r_bcd;
   assign bus.seg_out = r_valid ? w_seg : {DIGITS{SEG_BLANK}};

endmodule

// File: tb/tb_bin_bcd_seq_ctrl.sv
// Directed self-checking bench for bin_bcd_seq_ctrl (WIDTH=8, DIGITS=3).
module tb_bin_bcd_seq_ctrl;

   logic clk = 1'b0;
   logic rst;
   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   always #5 clk = ~clk;

   bin_bcd_seq_ctrl_if #(.WIDTH(8), .DIGITS(3)) bus ();

   bin_bcd_seq_ctrl #(.WIDTH(8), .DIGITS(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [6:0] seg_ref(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [11:0] bcd_ref(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic [20:0] segs_ref(input int v);
      return {seg_ref(v / 100), seg_ref((v / 10) % 10), seg_ref(v % 10)};
   endfunction

   // One start pulse, then a bounded 14-cycle observation window
   task automatic run_conv(input int v, input int chg_cyc, input int chg_val,
                           output int lat, output int ndone);
      lat   = -1;
      ndone = 0;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.bin_in = 8'(v);
      for (int cyc = 1; cyc <= 14; cyc++) begin
         @(negedge clk);
         if (cyc == 1) bus.start = 1'b0;
         if (cyc == chg_cyc) bus.bin_in = 8'(chg_val);
         if (bus.done) begin
            ndone++;
            lat = cyc;
         end
      end
   endtask

   initial begin
      int lat, nd, first_done, second_done, ndones;

      rst        = 1'b1;
      bus.start  = 1'b0;
      bus.bin_in = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_bcd",  32'(bus.bcd_out), 32'h000);
      chk("rst_seg",  32'(bus.seg_out), 32'h1FFFFF);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_seg", 32'(bus.seg_out), 32'h1FFFFF);

      run_conv(255, 0, 0, lat, nd);
      chk("lat_255",   32'(lat), 32'd9);
      chk("ndone_255", 32'(nd), 32'd1);
      chk("bcd_255",   32'(bus.bcd_out), 32'h255);
      chk("seg_255",   32'(bus.seg_out), 32'({7'b0100100, 7'b0010010, 7'b0010010}));

      run_conv(0, 0, 0, lat, nd);
      chk("bcd_0", 32'(bus.bcd_out), 32'h000);
      chk("seg_0", 32'(bus.seg_out), 32'({7'b1000000, 7'b1000000, 7'b1000000}));

      run_conv(9, 0, 0, lat, nd);
      chk("bcd_9",    32'(bus.bcd_out), 32'h009);
      chk("seg_9_d0", 32'(bus.seg_out[6:0]), 32'(7'b0010000));

      // Start held high across two conversions
      first_done  = 0;
      second_done = 0;
      ndones      = 0;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.bin_in = 8'd100;
      for (int cyc = 1; cyc <= 25; cyc++) begin
         @(negedge clk);
         if (cyc == 10) chk("held_idle_gap1", 32'(bus.busy), 32'd0);
         if (cyc == 20) chk("held_idle_gap2", 32'(bus.busy), 32'd0);
         if (bus.done) begin
            ndones++;
            if (first_done == 0) begin
               first_done = cyc;
               chk("held_bcd_100", 32'(bus.bcd_out), 32'h100);
               bus.bin_in = 8'd37;
            end else if (second_done == 0) begin
               second_done = cyc;
               chk("held_bcd_37", 32'(bus.bcd_out), 32'h037);
            end
         end
         if (cyc == 20) bus.start = 1'b0;
      end
      chk("held_first",  32'(first_done), 32'd9);
      chk("held_second", 32'(second_done), 32'd19);
      chk("held_ndone",  32'(ndones), 32'd2);

      run_conv(128, 3, 0, lat, nd);
      chk("bcd_128_chg", 32'(bus.bcd_out), 32'h128);
      chk("lat_128",     32'(lat), 32'd9);

      // Abort by reset mid-conversion
      ndones = 0;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.bin_in = 8'd200;
      for (int cyc = 1; cyc <= 4; cyc++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.done) ndones++;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_bcd",  32'(bus.bcd_out), 32'h000);
      chk("abort_seg",  32'(bus.seg_out), 32'h1FFFFF);
      for (int cyc = 1; cyc <= 12; cyc++) begin
         @(negedge clk);
         if (bus.done) ndones++;
      end
      chk("abort_nodone", 32'(ndones), 32'd0);
      run_conv(42, 0, 0, lat, nd);
      chk("after_abort_bcd", 32'(bus.bcd_out), 32'h042);
      chk("after_abort_seg", 32'(bus.seg_out), 32'({7'b1000000, 7'b0011001, 7'b0100100}));

      for (int v = 0; v <= 255; v++) begin
         run_conv(v, 0, 0, lat, nd);
         chk($sformatf("sweep_bcd_%0d", v),   32'(bus.bcd_out), 32'(bcd_ref(v)));
         chk($sformatf("sweep_seg_%0d", v),   32'(bus.seg_out), 32'(segs_ref(v)));
         chk($sformatf("sweep_ndone_%0d", v), 32'(nd), 32'd1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
